// File: rtl/mul_long_seq.sv
// mul_long_seq -- iterative 32x32->64 long-multiply sequencer (UMULL/SMULL/UMLAL/SMLAL).
//
// A radix-2 shift-add loop runs over the operand magnitudes for exactly WIDTH
// cycles. A single fix-up cycle then applies the sign and the optional
// accumulate, and registers the 64-bit result.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   start      in   operation request, sampled only in IDLE
//   is_signed  in   1 = signed multiply (captured with start)
//   accumulate in   1 = add acc_in to the product (captured with start)
//   a, b       in   multiplicand / multiplier (captured with start)
//   acc_in     in   {RdHi,RdLo} accumulate value (captured with start)
//   busy       out  high while in CALC and FIX
//   done       out  one-cycle completion pulse
//   result_hi  out  result bits [2*WIDTH-1:WIDTH]
//   result_lo  out  result bits [WIDTH-1:0]
module mul_long_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic                 accumulate,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc_in,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result_hi,
    output logic [WIDTH-1:0]     result_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 neg_q, neg_d;
    logic                 accum_q, accum_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   fixed;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CALC;
            S_CALC: if (count_q == LAST_CNT) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_CALC, S_FIX: busy = 1'b1;
            S_DONE:        done = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes; the most negative value maps onto itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    always_comb begin
        addend = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
        fixed  = neg_q ? (~prod_q + 1'b1) : prod_q;
        if (accum_q) begin
            fixed = fixed + acc_q;
        end
    end

    // Datapath next-state
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        result_d = result_q;
        count_d  = count_q;
        neg_d    = neg_q;
        accum_d  = accum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    prod_d   = '0;
                    acc_d    = acc_in;
                    count_d  = '0;
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    accum_d  = accumulate;
                end
            end
            S_CALC: begin
                prod_d   = prod_q + addend;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
            end
            S_FIX: begin
                result_d = fixed;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            accum_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            accum_q  <= accum_d;
        end
    end

    assign result_hi = result_q[2*WIDTH-1:WIDTH];
    assign result_lo = result_q[WIDTH-1:0];

endmodule
